// File: rtl/uart_4b5b_bridge.sv
// uart_4b5b_bridge: 4b5b link receiver, word FIFO and 8N1-style UART transmitter.
// Link frame: start bit, SYMS 5-bit codes (LSB first), stop bit.
module uart_4b5b_bridge #(
    parameter int RX_DIV  = 43,
    parameter int TX_DIV  = 54,
    parameter int SYMS    = 2,
    parameter int FIFO_AW = 4
) (
    input  logic             CLK_50M,
    input  logic             RST,
    input  logic             RS232_DTE_RXD,
    output logic             RS232_DCE_TXD,
    input  logic             clr_err,
    output logic             err_code,
    output logic             err_stop,
    output logic             err_ovf,
    output logic [FIFO_AW:0] fifo_level,
    output logic [7:0]       LED
);
    localparam int DW    = 4 * SYMS;
    localparam int NB    = 5 * SYMS;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int RCW   = $clog2(RX_DIV + 1);
    localparam int TCW   = $clog2(TX_DIV + 1);
    localparam int RBW   = $clog2(NB + 1);
    localparam int TBW   = $clog2(DW + 1);

    localparam logic [RCW-1:0] RX_FULL = RCW'(RX_DIV - 1);
    localparam logic [RCW-1:0] RX_HALF = RCW'(RX_DIV / 2 - 1);
    localparam logic [TCW-1:0] TX_FULL = TCW'(TX_DIV - 1);
    localparam logic [RBW-1:0] RX_LAST = RBW'(NB - 1);
    localparam logic [TBW-1:0] TX_LAST = TBW'(DW - 1);
    localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        R_IDLE, R_START, R_DATA, R_STOP, R_WAIT
    } rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE, T_START, T_DATA, T_STOP
    } tx_state_t;

    // Returns {valid, nibble}
    function automatic logic [4:0] dec5(input logic [4:0] c);
        logic [4:0] r;
        case (c)
            5'b11110: r = 5'h10;
            5'b01001: r = 5'h11;
            5'b10100: r = 5'h12;
            5'b10101: r = 5'h13;
            5'b01010: r = 5'h14;
            5'b01011: r = 5'h15;
            5'b01110: r = 5'h16;
            5'b01111: r = 5'h17;
            5'b10010: r = 5'h18;
            5'b10011: r = 5'h19;
            5'b10110: r = 5'h1A;
            5'b10111: r = 5'h1B;
            5'b11010: r = 5'h1C;
            5'b11011: r = 5'h1D;
            5'b11100: r = 5'h1E;
            5'b11101: r = 5'h1F;
            default:  r = 5'h00;
        endcase
        return r;
    endfunction

    logic rxd_m, rxd_s, rxd_q;

    rx_state_t      rx_st, rx_nx;
    logic [RCW-1:0] rcnt, rcnt_nx;
    logic [RBW-1:0] rbit, rbit_nx;
    logic [NB-1:0]  rsh, rsh_nx;
    logic           push_req, push_nx;
    logic [DW-1:0]  push_word, dec_word;
    logic           dec_ok, code_ev, stop_ev;

    logic [DW-1:0]      mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic               full, empty, push, pop, ovf_ev;
    logic [DW-1:0]      head;
    logic [DW+7:0]      head_ext;

    tx_state_t      tx_st, tx_nx;
    logic [TCW-1:0] tcnt, tcnt_nx;
    logic [TBW-1:0] tbit, tbit_nx;
    logic [DW-1:0]  tsh, tsh_nx;
    logic           txd, txd_nx;

    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
            rxd_q <= 1'b1;
        end else begin
            rxd_m <= RS232_DTE_RXD;
            rxd_s <= rxd_m;
            rxd_q <= rxd_s;
        end
    end

    always_comb begin
        logic [4:0] d;
        d        = '0;
        dec_ok   = 1'b1;
        dec_word = '0;
        for (int k = 0; k < SYMS; k++) begin
            d = dec5(rsh[5*k +: 5]);
            dec_word[4*k +: 4] = d[3:0];
            dec_ok = dec_ok & d[4];
        end
    end

    always_comb begin
        rx_nx   = rx_st;
        rcnt_nx = rcnt;
        rbit_nx = rbit;
        rsh_nx  = rsh;
        push_nx = 1'b0;
        code_ev = 1'b0;
        stop_ev = 1'b0;
        case (rx_st)
            R_IDLE: begin
                if (rxd_q && !rxd_s) begin
                    rx_nx   = R_START;
                    rcnt_nx = RX_HALF;
                end
            end
            R_START: begin
                if (rcnt == '0) begin
                    if (!rxd_s) begin
                        rx_nx   = R_DATA;
                        rcnt_nx = RX_FULL;
                        rbit_nx = '0;
                    end else begin
                        rx_nx = R_IDLE;
                    end
                end else begin
                    rcnt_nx = rcnt - 1'b1;
                end
            end
            R_DATA: begin
                if (rcnt == '0) begin
                    rsh_nx  = {rxd_s, rsh[NB-1:1]};
                    rcnt_nx = RX_FULL;
                    if (rbit == RX_LAST) rx_nx = R_STOP;
                    else rbit_nx = rbit + 1'b1;
                end else begin
                    rcnt_nx = rcnt - 1'b1;
                end
            end
            R_STOP: begin
                if (rcnt == '0) begin
                    if (rxd_s) begin
                        rx_nx = R_IDLE;
                        if (dec_ok) push_nx = 1'b1;
                        else code_ev = 1'b1;
                    end else begin
                        rx_nx   = R_WAIT;
                        stop_ev = 1'b1;
                    end
                end else begin
                    rcnt_nx = rcnt - 1'b1;
                end
            end
            R_WAIT: begin
                if (rxd_s) rx_nx = R_IDLE;
            end
            default: rx_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            rx_st     <= R_IDLE;
            rcnt      <= '0;
            rbit      <= '0;
            rsh       <= '0;
            push_req  <= 1'b0;
            push_word <= '0;
        end else begin
            rx_st    <= rx_nx;
            rcnt     <= rcnt_nx;
            rbit     <= rbit_nx;
            rsh      <= rsh_nx;
            push_req <= push_nx;
            if (push_nx) push_word <= dec_word;
        end
    end

    assign full     = (fifo_level == LVL_FULL);
    assign empty    = (fifo_level == '0);
    assign push     = push_req & ~full;
    assign ovf_ev   = push_req & full;
    assign head     = mem[rd_ptr];
    assign head_ext = {8'h00, head};

    always_ff @(posedge CLK_50M) begin
        if (push) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // A new word may also be taken at the last stop cycle for back-to-back frames
    always_comb begin
        tx_nx   = tx_st;
        tcnt_nx = tcnt;
        tbit_nx = tbit;
        tsh_nx  = tsh;
        txd_nx  = txd;
        pop     = 1'b0;
        case (tx_st)
            T_IDLE: begin
                txd_nx = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    tx_nx   = T_START;
                    tcnt_nx = TX_FULL;
                    tsh_nx  = head;
                    txd_nx  = 1'b0;
                end
            end
            T_START: begin
                if (tcnt == '0) begin
                    tx_nx   = T_DATA;
                    tcnt_nx = TX_FULL;
                    tbit_nx = '0;
                    txd_nx  = tsh[0];
                    tsh_nx  = tsh >> 1;
                end else begin
                    tcnt_nx = tcnt - 1'b1;
                end
            end
            T_DATA: begin
                if (tcnt == '0) begin
                    tcnt_nx = TX_FULL;
                    if (tbit == TX_LAST) begin
                        tx_nx  = T_STOP;
                        txd_nx = 1'b1;
                    end else begin
                        tbit_nx = tbit + 1'b1;
                        txd_nx  = tsh[0];
                        tsh_nx  = tsh >> 1;
                    end
                end else begin
                    tcnt_nx = tcnt - 1'b1;
                end
            end
            T_STOP: begin
                if (tcnt == '0) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        tx_nx   = T_START;
                        tcnt_nx = TX_FULL;
                        tsh_nx  = head;
                        txd_nx  = 1'b0;
                    end else begin
                        tx_nx  = T_IDLE;
                        txd_nx = 1'b1;
                    end
                end else begin
                    tcnt_nx = tcnt - 1'b1;
                end
            end
            default: tx_nx = T_IDLE;
        endcase
    end

    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            tx_st <= T_IDLE;
            tcnt  <= '0;
            tbit  <= '0;
            tsh   <= '0;
            txd   <= 1'b1;
            LED   <= 8'h00;
        end else begin
            tx_st <= tx_nx;
            tcnt  <= tcnt_nx;
            tbit  <= tbit_nx;
            tsh   <= tsh_nx;
            txd   <= txd_nx;
            if (pop) LED <= head_ext[7:0];
        end
    end

    assign RS232_DCE_TXD = txd;

    // A set event wins over a simultaneous clear
    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            err_code <= 1'b0;
            err_stop <= 1'b0;
            err_ovf  <= 1'b0;
        end else begin
            err_code <= code_ev | (err_code & ~clr_err);
            err_stop <= stop_ev | (err_stop & ~clr_err);
            err_ovf  <= ovf_ev | (err_ovf & ~clr_err);
        end
    end

endmodule
